// File: rtl/csa_seq_ctrl_pkg.sv
// Shared definitions for the serial carry-skip adder sequencer.
package csa_seq_ctrl_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/csa_seq_ctrl_nibble.sv
// csa_nibble: 4-bit carry-skip adder slice; select marks a full-propagate slice
// whose carry-out bypasses the ripple chain.
module csa_nibble
    import csa_seq_ctrl_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] s,
    output logic               cout,
    output logic               select
);

    logic [SLICE_W-1:0] p;
    logic [SLICE_W-1:0] g;
    logic [SLICE_W:0]   c;

    always_comb begin
        p    = a ^ b;
        g    = a & b;
        c    = '0;
        c[0] = cin;
        for (int k = 0; k < SLICE_W; k++) begin
            c[k+1] = g[k] | (p[k] & c[k]);
        end
        s      = p ^ c[SLICE_W-1:0];
        select = &p;
        cout   = select ? cin : c[SLICE_W];
    end

endmodule

// File: rtl/csa_seq_ctrl.sv
// Sequencer computing a + b + cin one nibble per clock through a single
// shared carry-skip slice.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for start; sum/cout hold the last result
//   RUN   | one slice per cycle, index 0 .. NIBBLES-1
//   DONE  | single-cycle done pulse; a start here is taken like in IDLE
module csa_seq_ctrl
    import csa_seq_ctrl_pkg::*;
#(
    parameter  int NIBBLES = 4,
    localparam int W       = SLICE_W * NIBBLES
)
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic [4:0]   skip_cnt
);

    localparam int            IW   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    state_t             state;
    logic [W-1:0]       a_q;
    logic [W-1:0]       b_q;
    logic               cy;
    logic [IW-1:0]      idx;

    logic [SLICE_W-1:0] slice_s;
    logic               slice_c;
    logic               slice_sel;

    csa_nibble u_slice (
        .a      (a_q[idx*SLICE_W +: SLICE_W]),
        .b      (b_q[idx*SLICE_W +: SLICE_W]),
        .cin    (cy),
        .s      (slice_s),
        .cout   (slice_c),
        .select (slice_sel)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            cy       <= 1'b0;
            idx      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sum      <= '0;
            cout     <= 1'b0;
            skip_cnt <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_q      <= a;
                        b_q      <= b;
                        cy       <= cin;
                        idx      <= '0;
                        skip_cnt <= '0;
                        busy     <= 1'b1;
                        state    <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    // start is deliberately not looked at while running
                    sum[idx*SLICE_W +: SLICE_W] <= slice_s;
                    cy <= slice_c;
                    if (slice_sel) begin
                        skip_cnt <= skip_cnt + 5'd1;
                    end
                    if (idx == LAST) begin
                        cout  <= slice_c;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_csa_seq_ctrl.sv
// Self-checking bench for csa_seq_ctrl: vector table plus hand-written
// sequences, with a result queue popped on every done pulse.
module tb_csa_seq_ctrl;

    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic [4:0]   skip;
    } exp_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        exp_t         e;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic [4:0]   skip_cnt;

    int   errors = 0;
    int   checks = 0;
    int   done_cnt = 0;
    exp_t exp_q[$];
    vec_t vecs[$];

    csa_seq_ctrl #(.NIBBLES(NIBBLES)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .cout     (cout),
        .skip_cnt (skip_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Reference: plain integer addition, skip counted per nibble as all-propagate
    function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc);
        exp_t   r;
        logic [W:0] full;
        int     c;
        int     na;
        int     nb;
        full   = {1'b0, ta} + {1'b0, tb} + {{W{1'b0}}, tc};
        r.sum  = full[W-1:0];
        r.cout = full[W];
        r.skip = '0;
        c = tc;
        for (int n = 0; n < NIBBLES; n++) begin
            na = int'(ta[4*n +: 4]);
            nb = int'(tb[4*n +: 4]);
            if ((na ^ nb) == 15) r.skip = r.skip + 5'd1;
            c = (na + nb + c) >> 4;
        end
        return r;
    endfunction

    always begin
        @(posedge clk);
        #1;
        if (done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_done", 64'(done), 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sum", 64'(sum), 64'(e.sum));
                check("cout", 64'(cout), 64'(e.cout));
                check("skip_cnt", 64'(skip_cnt), 64'(e.skip));
            end
        end
    end

    task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc, input exp_t e);
        @(negedge clk);
        a     = ta;
        b     = tb;
        cin   = tc;
        start = 1'b1;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        cin   = 1'($urandom);
    endtask

    task automatic wait_done(input string name, input int req_edges);
        int k;
        k = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (done) begin
                k = n;
                break;
            end
        end
        check(name, 64'(k), 64'(req_edges));
    endtask

    initial begin
        exp_t e1;
        exp_t e2;
        int   d0;

        vecs.push_back('{a:16'hFFFF, b:16'h0001, cin:1'b0, e:'{sum:16'h0000, cout:1'b1, skip:5'd3}});
        vecs.push_back('{a:16'h1234, b:16'h4321, cin:1'b1, e:'{sum:16'h5556, cout:1'b0, skip:5'd0}});
        vecs.push_back('{a:16'hFFFF, b:16'h0000, cin:1'b1, e:'{sum:16'h0000, cout:1'b1, skip:5'd4}});
        vecs.push_back('{a:16'hF0F0, b:16'h0F0F, cin:1'b0, e:'{sum:16'hFFFF, cout:1'b0, skip:5'd4}});
        vecs.push_back('{a:16'h8000, b:16'h8000, cin:1'b0, e:'{sum:16'h0000, cout:1'b1, skip:5'd0}});
        vecs.push_back('{a:16'h0000, b:16'h0000, cin:1'b0, e:'{sum:16'h0000, cout:1'b0, skip:5'd0}});
        for (int i = 0; i < 6; i++) begin
            vec_t v;
            v.a   = W'($urandom);
            v.b   = W'($urandom);
            v.cin = 1'($urandom);
            v.e   = model(v.a, v.b, v.cin);
            vecs.push_back(v);
        end

        #1;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_sum", 64'(sum), 64'd0);
        check("reset_cout", 64'(cout), 64'd0);
        check("reset_skip", 64'(skip_cnt), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            start_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].e);
            check("busy_in_run", 64'(busy), 64'd1);
            wait_done("latency", NIBBLES);
            check("busy_in_done", 64'(busy), 64'd0);
            repeat (2) @(posedge clk);
        end

        // start pulsed mid-operation must be ignored
        d0 = done_cnt;
        e1 = model(16'h1111, 16'h2222, 1'b0);
        start_op(16'h1111, 16'h2222, 1'b0, e1);
        @(posedge clk);
        #1;
        @(negedge clk);
        a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("latency_ignored_start", NIBBLES - 2);
        repeat (10) @(posedge clk);
        #1;
        check("single_done_pulse", 64'(done_cnt - d0), 64'd1);
        check("no_queued_op", 64'(busy), 64'd0);

        // back-to-back: second start issued in the DONE cycle
        e1 = model(16'hABCD, 16'h1234, 1'b1);
        start_op(16'hABCD, 16'h1234, 1'b1, e1);
        wait_done("b2b_first_latency", NIBBLES);
        e2 = '{sum:16'h0002, cout:1'b0, skip:5'd0};
        check("b2b_first_held", 64'(sum), 64'(e1.sum));
        start_op(16'h0001, 16'h0001, 1'b0, e2);
        wait_done("b2b_second_latency", NIBBLES);
        repeat (2) @(posedge clk);

        // reset in the middle of RUN abandons the operation
        start_op(16'h5A5A, 16'hA5A5, 1'b1, model(16'h5A5A, 16'hA5A5, 1'b1));
        @(posedge clk);
        #1;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        d0 = done_cnt;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_sum", 64'(sum), 64'd0);
        check("rst_cout", 64'(cout), 64'd0);
        check("rst_skip", 64'(skip_cnt), 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        a = 16'h0FFF; b = 16'h0001; cin = 1'b0; start = 1'b1;
        exp_q.push_back(model(16'h0FFF, 16'h0001, 1'b0));
        @(posedge clk);
        #1;
        start = 1'b0;
        check("no_done_after_reset", 64'(done_cnt - d0), 64'd0);
        wait_done("post_reset_latency", NIBBLES);

        repeat (4) @(posedge clk);
        #2;
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/csa_seq_ctrl.md
CSA_SEQ_CTRL -- requirements
Module: csa_seq_ctrl

Interface
REQ-001 The block SHALL have parameter NIBBLES, default 4, giving the number of 4-bit slices per operation (range 2..16).
REQ-002 The block SHALL have derived constant W = 4*NIBBLES, giving the operand width.
REQ-003 Port clk, input, 1 bit: single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port start, input, 1 bit: operation request, sampled only when the block is not busy.
REQ-006 Port a, input, W bits: operand A, captured with start.
REQ-007 Port b, input, W bits: operand B, captured with start.
REQ-008 Port cin, input, 1 bit: carry-in, captured with start.
REQ-009 Port busy, output, 1 bit: high while an operation is in progress.
REQ-010 Port done, output, 1 bit: one-cycle pulse when sum/cout become valid.
REQ-011 Port sum, output, W bits: result, held stable from done until the next accepted start.
REQ-012 Port cout, output, 1 bit: final carry, held stable with sum.
REQ-013 Port skip_cnt, output, 5 bits: number of slices in the operation whose carry took the skip path (all 4 propagate bits set).

Function
REQ-014 The block SHALL compute {cout,sum} = a + b + cin over W bits, one 4-bit slice per clock, reusing one carry-skip slice.
REQ-015 The FSM SHALL have states IDLE, RUN and DONE.
REQ-016 IDLE with start=1: latch a, b and cin; set slice index to 0; clear skip_cnt; go to RUN; busy=1 from the next cycle.
REQ-017 RUN: each cycle, slice index i SHALL process a[4i+3:4i], b[4i+3:4i] and the carry register, write sum[4i+3:4i], load the carry register with the slice carry-out, increment skip_cnt if the slice select is 1, and increment i.
REQ-018 RUN at i = NIBBLES-1: after processing, go to DONE and load cout from the slice carry-out.
REQ-019 DONE: done=1 and busy=0 for exactly one cycle, then go to IDLE.
REQ-020 A start in DONE SHALL be accepted exactly as in IDLE (back-to-back operation), with no idle cycle required.
REQ-021 Latency: the start edge at cycle T SHALL give done=1 in cycle T+NIBBLES+1, and throughput SHALL be one operation per NIBBLES+1 cycles.
REQ-022 start while in RUN SHALL be ignored, with no queuing and no effect on the operation in flight.
REQ-023 Operand inputs SHALL be don't-care except in the cycle where start is accepted.
REQ-024 The partially updated sum SHALL be visible during RUN, and consumers SHALL qualify sum with done.
REQ-025 Slice index wrap: the index SHALL never exceed NIBBLES-1, and on the next accepted start it SHALL reset to 0.

Reset
REQ-026 On rst_n=0, the block SHALL immediately force state=IDLE, busy=0, done=0, sum=0, cout=0, skip_cnt=0, slice index 0 and carry register 0.
REQ-027 Reset during RUN SHALL abandon the operation with no done pulse; a start is accepted on the first clock after rst_n rises.

Structure
REQ-028 A shared package SHALL hold the FSM state enumeration (IDLE/RUN/DONE) and the slice width constant 4.
REQ-029 The block SHALL instantiate one sub-module, csa_nibble: a 4-bit carry-skip adder slice with outputs s[3:0], cout and select (AND of the four propagate bits).
REQ-030 The block SHALL have no other arithmetic outside csa_nibble except the index and skip_cnt counters.

Verification (NIBBLES=4)
REQ-031 Start with a=0xFFFF, b=0x0001, cin=0 -> done at T+5, sum=0x0000, cout=1, skip_cnt=3.
REQ-032 Start with a=0x1234, b=0x4321, cin=1 -> sum=0x5556, cout=0, skip_cnt=0.
REQ-033 Start with a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1, skip_cnt=4.
REQ-034 Pulse start again 2 cycles into RUN with different operands -> first result unchanged; exactly one done pulse.
REQ-035 Start asserted in the DONE cycle with a=0x0001, b=0x0001 -> the second done occurs 5 cycles later with sum=0x0002 and the first result held until then.
REQ-036 Drop rst_n during RUN -> all outputs 0 asynchronously, no done pulse; a new start after release completes normally.
